// File: rtl/sal_cmd_sched.sv
// Channel-level DRAM command scheduler: grants at most one bank request per cycle by class
// priority (column > ACT > PRE > REF) with per-class round-robin, enforcing tRRD/tCCD/tWTR/tRTW.
module sal_cmd_sched #(
  parameter int NUM_BANKS = 4,
  parameter int T_RRD     = 2,
  parameter int T_CCD     = 2,
  parameter int T_WTR     = 3,
  parameter int T_RTW     = 4,
  parameter int RA_W      = 16,
  parameter int CA_W      = 10,
  parameter int ID_W      = 4,
  parameter int LEN_W     = 8,
  localparam int BA_W     = $clog2(NUM_BANKS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_BANKS-1:0]              act_req_i,
  input  logic [NUM_BANKS-1:0]              rd_req_i,
  input  logic [NUM_BANKS-1:0]              wr_req_i,
  input  logic [NUM_BANKS-1:0]              pre_req_i,
  input  logic [NUM_BANKS-1:0]              ref_req_i,
  input  logic [NUM_BANKS-1:0][RA_W-1:0]    ra_i,
  input  logic [NUM_BANKS-1:0][CA_W-1:0]    ca_i,
  input  logic [NUM_BANKS-1:0][ID_W-1:0]    id_i,
  input  logic [NUM_BANKS-1:0][LEN_W-1:0]   len_i,
  output logic [NUM_BANKS-1:0]              act_gnt_o,
  output logic [NUM_BANKS-1:0]              rd_gnt_o,
  output logic [NUM_BANKS-1:0]              wr_gnt_o,
  output logic [NUM_BANKS-1:0]              pre_gnt_o,
  output logic [NUM_BANKS-1:0]              ref_gnt_o,
  output logic                              cmd_valid_o,
  output logic [2:0]                        cmd_o,
  output logic [BA_W-1:0]                   cmd_ba_o,
  output logic [RA_W-1:0]                   cmd_ra_o,
  output logic [CA_W-1:0]                   cmd_ca_o,
  output logic [ID_W-1:0]                   cmd_id_o,
  output logic [LEN_W-1:0]                  cmd_len_o
);

  // Handshake: each *_req_i bit is a bank's valid and the matching *_gnt_o bit is this block's
  // ready. A request transfers on the rising edge where both are high; the bank holds request
  // and payload stable until then. A request withdrawn before its grant is forgotten.

  localparam int T_MAX_A = (T_RRD > T_CCD) ? T_RRD : T_CCD;
  localparam int T_MAX_B = (T_WTR > T_RTW) ? T_WTR : T_RTW;
  localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int CW      = $clog2(T_MAX + 1);

  localparam logic [CW-1:0] RRD_RL = CW'(T_RRD - 1);
  localparam logic [CW-1:0] CCD_RL = CW'(T_CCD - 1);
  localparam logic [CW-1:0] WTR_RL = CW'(T_WTR - 1);
  localparam logic [CW-1:0] RTW_RL = CW'(T_RTW - 1);

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_PRE = 3'd4;
  localparam logic [2:0] CMD_REF = 3'd5;

  logic [CW-1:0]   rrd_cnt, ccd_cnt, wtr_cnt, rtw_cnt;
  logic [BA_W-1:0] rr_col, rr_act, rr_pre, rr_ref;

  logic [NUM_BANKS-1:0] col_cand, act_cand;
  logic [BA_W:0]        col_pick, act_pick, pre_pick, ref_pick;
  logic                 rd_ok, wr_ok, is_col;
  logic [2:0]           win_cmd;
  logic [BA_W-1:0]      win_ba;

  // Returns {found, index} of the first set bit at or after ptr, wrapping around.
  function automatic logic [BA_W:0] rr_pick(input logic [NUM_BANKS-1:0] req,
                                            input logic [BA_W-1:0] ptr);
    logic [BA_W:0]   res;
    logic [BA_W-1:0] idx;
    res = '0;
    for (int i = NUM_BANKS - 1; i >= 0; i--) begin
      idx = ptr + BA_W'(i);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  function automatic logic [CW-1:0] dec_sat(input logic [CW-1:0] c);
    return (c == '0) ? '0 : c - CW'(1);
  endfunction

  assign rd_ok    = (ccd_cnt == '0) && (wtr_cnt == '0);
  assign wr_ok    = (ccd_cnt == '0) && (rtw_cnt == '0);
  // A bank raising RD and WR together offers only its RD.
  assign col_cand = (rd_req_i & {NUM_BANKS{rd_ok}})
                  | (wr_req_i & ~rd_req_i & {NUM_BANKS{wr_ok}});
  assign act_cand = act_req_i & {NUM_BANKS{rrd_cnt == '0}};

  assign col_pick = rr_pick(col_cand, rr_col);
  assign act_pick = rr_pick(act_cand, rr_act);
  assign pre_pick = rr_pick(pre_req_i, rr_pre);
  assign ref_pick = rr_pick(ref_req_i, rr_ref);

  always_comb begin
    act_gnt_o = '0;
    rd_gnt_o  = '0;
    wr_gnt_o  = '0;
    pre_gnt_o = '0;
    ref_gnt_o = '0;
    win_cmd   = CMD_NOP;
    win_ba    = '0;
    if (!rst) begin
      if (col_pick[BA_W]) begin
        win_ba = col_pick[BA_W-1:0];
        if (rd_req_i[win_ba]) begin
          rd_gnt_o[win_ba] = 1'b1;
          win_cmd          = CMD_RD;
        end else begin
          wr_gnt_o[win_ba] = 1'b1;
          win_cmd          = CMD_WR;
        end
      end else if (act_pick[BA_W]) begin
        win_ba            = act_pick[BA_W-1:0];
        act_gnt_o[win_ba] = 1'b1;
        win_cmd           = CMD_ACT;
      end else if (pre_pick[BA_W]) begin
        win_ba            = pre_pick[BA_W-1:0];
        pre_gnt_o[win_ba] = 1'b1;
        win_cmd           = CMD_PRE;
      end else if (ref_pick[BA_W]) begin
        win_ba            = ref_pick[BA_W-1:0];
        ref_gnt_o[win_ba] = 1'b1;
        win_cmd           = CMD_REF;
      end
    end
  end

  assign is_col = (win_cmd == CMD_RD) || (win_cmd == CMD_WR);

  always_ff @(posedge clk) begin
    if (rst) begin
      rrd_cnt     <= '0;
      ccd_cnt     <= '0;
      wtr_cnt     <= '0;
      rtw_cnt     <= '0;
      rr_col      <= '0;
      rr_act      <= '0;
      rr_pre      <= '0;
      rr_ref      <= '0;
      cmd_valid_o <= 1'b0;
      cmd_o       <= CMD_NOP;
      cmd_ba_o    <= '0;
      cmd_ra_o    <= '0;
      cmd_ca_o    <= '0;
      cmd_id_o    <= '0;
      cmd_len_o   <= '0;
    end else begin
      rrd_cnt <= (win_cmd == CMD_ACT) ? RRD_RL : dec_sat(rrd_cnt);
      ccd_cnt <= is_col               ? CCD_RL : dec_sat(ccd_cnt);
      wtr_cnt <= (win_cmd == CMD_WR)  ? WTR_RL : dec_sat(wtr_cnt);
      rtw_cnt <= (win_cmd == CMD_RD)  ? RTW_RL : dec_sat(rtw_cnt);

      if (is_col)               rr_col <= win_ba + BA_W'(1);
      if (win_cmd == CMD_ACT)   rr_act <= win_ba + BA_W'(1);
      if (win_cmd == CMD_PRE)   rr_pre <= win_ba + BA_W'(1);
      if (win_cmd == CMD_REF)   rr_ref <= win_ba + BA_W'(1);

      cmd_valid_o <= (win_cmd != CMD_NOP);
      cmd_o       <= win_cmd;
      if (win_cmd != CMD_NOP) begin
        cmd_ba_o  <= win_ba;
        cmd_ra_o  <= ra_i[win_ba];
        cmd_ca_o  <= ca_i[win_ba];
        cmd_id_o  <= is_col ? id_i[win_ba]  : '0;
        cmd_len_o <= is_col ? len_i[win_ba] : '0;
      end
    end
  end

endmodule

// File: tb/tb_sal_cmd_sched.sv
// Bench for sal_cmd_sched: directed scenarios with literal checks, plus a timestamp-based
// scheduling model compared against grants and the command bus on every cycle.
module tb_sal_cmd_sched;

  localparam int NB    = 4;
  localparam int T_RRD = 2;
  localparam int T_CCD = 2;
  localparam int T_WTR = 3;
  localparam int T_RTW = 4;
  localparam int CMD_W = 44;

  logic clk, rst;
  logic [NB-1:0] act_req, rd_req, wr_req, pre_req, ref_req;
  logic [NB-1:0][15:0] ra;
  logic [NB-1:0][9:0]  ca;
  logic [NB-1:0][3:0]  id;
  logic [NB-1:0][7:0]  len;
  logic [NB-1:0] act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
  logic          cmd_valid;
  logic [2:0]    cmd;
  logic [1:0]    cmd_ba;
  logic [15:0]   cmd_ra;
  logic [9:0]    cmd_ca;
  logic [3:0]    cmd_id;
  logic [7:0]    cmd_len;

  int n_cmp = 0;
  int n_fail = 0;

  sal_cmd_sched #(
    .NUM_BANKS(NB), .T_RRD(T_RRD), .T_CCD(T_CCD), .T_WTR(T_WTR), .T_RTW(T_RTW),
    .RA_W(16), .CA_W(10), .ID_W(4), .LEN_W(8)
  ) dut (
    .clk(clk), .rst(rst),
    .act_req_i(act_req), .rd_req_i(rd_req), .wr_req_i(wr_req),
    .pre_req_i(pre_req), .ref_req_i(ref_req),
    .ra_i(ra), .ca_i(ca), .id_i(id), .len_i(len),
    .act_gnt_o(act_gnt), .rd_gnt_o(rd_gnt), .wr_gnt_o(wr_gnt),
    .pre_gnt_o(pre_gnt), .ref_gnt_o(ref_gnt),
    .cmd_valid_o(cmd_valid), .cmd_o(cmd), .cmd_ba_o(cmd_ba),
    .cmd_ra_o(cmd_ra), .cmd_ca_o(cmd_ca), .cmd_id_o(cmd_id), .cmd_len_o(cmd_len)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard / model ----------------
  // Command-bus words expected one cycle after each modelled grant decision.
  logic [CMD_W-1:0] exp_q[$];
  logic [CMD_W-1:0] last_word = '0;
  int cyc = 0;
  int last_act = -100, last_col = -100, last_wr = -100, last_rd = -100;
  int rr_col = 0, rr_act = 0, rr_pre = 0, rr_ref = 0;

  function automatic int pick(input logic [NB-1:0] req, input int ptr);
    for (int i = 0; i < NB; i++) if (req[(ptr + i) % NB]) return (ptr + i) % NB;
    return -1;
  endfunction

  initial exp_q.push_back('0);

  always @(negedge clk) begin : model_cmp
    logic [CMD_W-1:0] exp_word, nxt;
    logic [NB-1:0] e_act, e_rd, e_wr, e_pre, e_ref, cand;
    bit rd_ok, wr_ok;
    int w;
    int kind; // 0 none, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 REF
    if (exp_q.size() == 0) begin
      check("cmd_q_empty", 64'd1, 64'd0);
    end else begin
      exp_word = exp_q.pop_front();
      check("cmd_bus", {cmd_valid, cmd, cmd_ba, cmd_ra, cmd_ca, cmd_id, cmd_len}, exp_word);
    end

    e_act = '0; e_rd = '0; e_wr = '0; e_pre = '0; e_ref = '0;
    kind = 0; w = -1;
    if (!rst) begin
      rd_ok = (cyc - last_col >= T_CCD) && (cyc - last_wr >= T_WTR);
      wr_ok = (cyc - last_col >= T_CCD) && (cyc - last_rd >= T_RTW);
      for (int b = 0; b < NB; b++)
        cand[b] = (rd_req[b] && rd_ok) || (wr_req[b] && !rd_req[b] && wr_ok);
      w = pick(cand, rr_col);
      if (w >= 0) begin
        kind = rd_req[w] ? 2 : 3;
        rr_col = (w + 1) % NB;
        last_col = cyc;
        if (kind == 2) begin e_rd[w] = 1'b1; last_rd = cyc; end
        else begin e_wr[w] = 1'b1; last_wr = cyc; end
      end else begin
        w = (cyc - last_act >= T_RRD) ? pick(act_req, rr_act) : -1;
        if (w >= 0) begin
          kind = 1; e_act[w] = 1'b1; rr_act = (w + 1) % NB; last_act = cyc;
        end else begin
          w = pick(pre_req, rr_pre);
          if (w >= 0) begin
            kind = 4; e_pre[w] = 1'b1; rr_pre = (w + 1) % NB;
          end else begin
            w = pick(ref_req, rr_ref);
            if (w >= 0) begin
              kind = 5; e_ref[w] = 1'b1; rr_ref = (w + 1) % NB;
            end
          end
        end
      end
    end
    check("grants", {act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt},
          {e_act, e_rd, e_wr, e_pre, e_ref});

    if (rst) begin
      last_act = -100; last_col = -100; last_wr = -100; last_rd = -100;
      rr_col = 0; rr_act = 0; rr_pre = 0; rr_ref = 0;
      nxt = '0;
    end else if (kind != 0) begin
      nxt = {1'b1, 3'(kind), 2'(w), ra[w], ca[w],
             (kind == 2 || kind == 3) ? id[w] : 4'd0,
             (kind == 2 || kind == 3) ? len[w] : 8'd0};
    end else begin
      nxt = {4'b0000, last_word[CMD_W-5:0]};
    end
    last_word = nxt;
    exp_q.push_back(nxt);
    cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_req();
    act_req = '0; rd_req = '0; wr_req = '0; pre_req = '0; ref_req = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_req();
    step();
    step();
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    act_req = '1; rd_req = '1; wr_req = '1; pre_req = '1; ref_req = '1;
    for (int b = 0; b < NB; b++) begin
      ra[b]  = 16'h1000 + 16'(b * 16'h111);
      ca[b]  = 10'h20 + 10'(b);
      id[b]  = 4'(b + 1);
      len[b] = 8'h10 + 8'(b);
    end

    // Reset with every request high.
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_gnt", {act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt}, 0);
      check("rst_cmd", {cmd_valid, cmd}, 0);
    end
    rst = 1'b0;
    settle();
    check("first_rd", rd_gnt, 4'b0001);
    check("first_other", {act_gnt, wr_gnt, pre_gnt, ref_gnt}, 0);
    step();
    clear_req();
    step();

    // Round-robin over column reads, tCCD=2.
    do_reset();
    rd_req = 4'hF;
    for (int k = 0; k <= 8; k++) begin
      settle();
      check($sformatf("rr_gnt_%0d", k), rd_gnt,
            (k % 2 == 0) ? (64'd1 << ((k / 2) % 4)) : 64'd0);
      if (k % 2 == 1)
        check($sformatf("rr_cmd_%0d", k), {cmd_valid, cmd, cmd_ba},
              {1'b1, 3'd2, 2'(((k - 1) / 2) % 4)});
      else if (k > 0)
        check($sformatf("rr_idle_%0d", k), cmd_valid, 0);
      step();
    end
    clear_req();

    // Priority: ACT > PRE > REF with tRRD gap.
    do_reset();
    act_req = 4'b0010; pre_req = 4'b0100; ref_req = 4'b1000;
    settle();
    check("prio_c0", {act_gnt, pre_gnt, ref_gnt}, {4'b0010, 4'b0000, 4'b0000});
    step();
    settle();
    check("prio_c1", {act_gnt, pre_gnt, ref_gnt}, {4'b0000, 4'b0100, 4'b0000});
    check("prio_c1_cmd", {cmd_valid, cmd, cmd_ba, cmd_ra, cmd_id, cmd_len},
          {1'b1, 3'd1, 2'd1, 16'h1111, 4'd0, 8'd0});
    step();
    pre_req = '0;
    settle();
    check("prio_c2", {act_gnt, pre_gnt, ref_gnt}, {4'b0010, 4'b0000, 4'b0000});
    step();
    act_req = '0;
    settle();
    check("prio_c3", {act_gnt, pre_gnt, ref_gnt}, {4'b0000, 4'b0000, 4'b1000});
    step();
    clear_req();
    step();

    // WR -> RD turnaround.
    do_reset();
    wr_req = 4'b0001; rd_req = 4'b0010;
    settle();
    check("wtr_c0", {wr_gnt, rd_gnt}, {4'b0001, 4'b0000});
    step();
    wr_req = '0;
    settle();
    check("wtr_c1", rd_gnt, 0);
    check("wtr_c1_cmd", {cmd_valid, cmd, cmd_ba, cmd_ca, cmd_id, cmd_len},
          {1'b1, 3'd3, 2'd0, 10'h20, 4'd1, 8'h10});
    step();
    settle();
    check("wtr_c2", rd_gnt, 0);
    step();
    settle();
    check("wtr_c3", rd_gnt, 4'b0010);
    step();
    clear_req();

    // RD -> WR turnaround.
    do_reset();
    rd_req = 4'b0001; wr_req = 4'b0010;
    settle();
    check("rtw_c0", {rd_gnt, wr_gnt}, {4'b0001, 4'b0000});
    step();
    rd_req = '0;
    for (int c = 1; c <= 3; c++) begin
      settle();
      check($sformatf("rtw_c%0d", c), wr_gnt, 0);
      step();
    end
    settle();
    check("rtw_c4", wr_gnt, 4'b0010);
    step();
    clear_req();

    // Request dropped before eligibility leaves no trace.
    do_reset();
    wr_req = 4'b0001;
    settle();
    check("drop_c0", wr_gnt, 4'b0001);
    step();
    wr_req = '0; rd_req = 4'b0100;
    settle();
    check("drop_c1", rd_gnt, 0);
    step();
    settle();
    check("drop_c2", rd_gnt, 0);
    step();
    rd_req = '0;
    settle();
    check("drop_c3", {rd_gnt, cmd_valid}, 0);
    step();
    settle();
    check("drop_c4", {rd_gnt, cmd_valid}, 0);
    step();
    rd_req = 4'b1010;
    settle();
    check("drop_rr", rd_gnt, 4'b0010);
    step();
    clear_req();

    // Mid-stream reset discards the pending WR->RD restriction.
    do_reset();
    wr_req = 4'b0001;
    settle();
    check("mrst_c0", wr_gnt, 4'b0001);
    step();
    wr_req = '0; rd_req = 4'b0010; rst = 1'b1;
    settle();
    check("mrst_c1", {act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt}, 0);
    step();
    rst = 1'b0;
    settle();
    check("mrst_c2", rd_gnt, 4'b0010);
    check("mrst_c2_cmd", {cmd_valid, cmd, cmd_ba, cmd_ra, cmd_ca, cmd_id, cmd_len}, 0);
    step();
    clear_req();
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sal_cmd_sched.md
# sal_cmd_sched

Channel-level command scheduler. It sits at the far end of the per-bank request/grant handshake. It collects ACT/RD/WR/PRE/REF requests from `NUM_BANKS` bank controllers and grants at most one per cycle. Grants are chosen by fixed class priority plus per-class round-robin across banks. The scheduler enforces inter-bank channel timing (tRRD, tCCD, tWTR, tRTW) and drives one registered DRAM command per granted request, with the winner's row/column/ID/length forwarded.

## Interface

Parameters:
- `NUM_BANKS`, 4, number of bank controllers (power of two, 2..8)
- `T_RRD`, 2, min cycles ACT→ACT (different banks)
- `T_CCD`, 2, min cycles column cmd → column cmd
- `T_WTR`, 3, min cycles WR → RD
- `T_RTW`, 4, min cycles RD → WR

Ports:
- `clk`  in  1  clock; everything on rising edge
- `rst`  in  1  synchronous, active-high reset
- `act_req_i`, `rd_req_i`, `wr_req_i`, `pre_req_i`, `ref_req_i`  in  `NUM_BANKS` each  per-bank request bits
- `ra_i`  in  `NUM_BANKS` × `dram_ra_t`  per-bank row address
- `ca_i`  in  `NUM_BANKS` × `dram_ca_t`  per-bank column address
- `id_i`  in  `NUM_BANKS` × `axi_id_t`  per-bank transaction ID
- `len_i`  in  `NUM_BANKS` × `axi_len_t`  per-bank burst length
- `act_gnt_o`, `rd_gnt_o`, `wr_gnt_o`, `pre_gnt_o`, `ref_gnt_o`  out  `NUM_BANKS` each  one-hot-or-zero grants, combinational
- `cmd_valid_o`  out  1  DRAM command issued this cycle
- `cmd_o`  out  3  0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 REF
- `cmd_ba_o`  out  $clog2(`NUM_BANKS`)  target bank
- `cmd_ra_o` / `cmd_ca_o`  out  `dram_ra_t` / `dram_ca_t`  address of issued command
- `cmd_id_o` / `cmd_len_o`  out  `axi_id_t` / `axi_len_t`  forwarded for RD/WR, zero otherwise

## Operation

- **One grant per cycle.** Across all 5×`NUM_BANKS` grant bits, at most one is high in any cycle.
- **Class priority:** RD/WR (column) > ACT > PRE > REF.
  - RD and WR share one column class.
  - A bank asserting both RD and WR is a protocol error; RD wins.
- **Eligibility per class:**
  - Column RD: `ccd_cnt==0` and `wtr_cnt==0`.
  - Column WR: `ccd_cnt==0` and `rtw_cnt==0`.
  - ACT: `rrd_cnt==0`.
  - PRE and REF: always eligible.
  - An ineligible class is skipped and the next class is considered in the same cycle.
- **Round-robin:**
  - Each class keeps its own pointer `rr_<class>` (bank index). Search starts at `rr` and wraps modulo `NUM_BANKS`.
  - After a grant, that class's pointer becomes `(winner+1) mod NUM_BANKS`.
  - Pointers of other classes are unchanged.
- **Handshake:**
  - A grant is combinational from the current-cycle request and the registered counters/pointers.
  - A request is consumed when request and grant are both high at the clock edge.
  - The bank controller must hold its request, address, ID and length stable until granted.
  - A request that drops before it is granted is simply lost, with no side effect.
- **Timing counters:** 4 down-counters, width $clog2(max param + 1), saturating at 0.
  - On a grant they reload: ACT → `rrd_cnt = T_RRD-1`; any column command → `ccd_cnt = T_CCD-1`; WR → `wtr_cnt = T_WTR-1`; RD → `rtw_cnt = T_RTW-1`.
  - All other non-zero counters decrement every cycle.
  - A reload takes precedence over a decrement in the same cycle.
  - A parameter value of 1 reloads to 0, meaning back-to-back issue is allowed.
- **Command register:** on a grant, latch `cmd`, `ba`, `ra`, `ca`, `id`, `len` from the winner and set `cmd_valid_o=1`. Otherwise `cmd_valid_o=0` and `cmd_o=NOP`; the other fields hold their last value.
- **Reset:**
  - `cmd_valid_o=0`, `cmd_o=0`, `cmd_ba_o`/`cmd_ra_o`/`cmd_ca_o`/`cmd_id_o`/`cmd_len_o`=0.
  - All counters = 0 and all `rr` pointers = 0.
  - All grants are forced to 0 while `rst` is high.
  - Reset asserted mid-stream takes effect at the next edge; any pending timing restriction is discarded.

## Timing

- **Grant → command latency:** the grant is in cycle N; the command appears on the `cmd_*` outputs in cycle N+1, valid for exactly one cycle.
- **Command spacing:**
  - Two column grants are at least `T_CCD` cycles apart.
  - Two ACT grants are at least `T_RRD` cycles apart.
  - WR grant at N → earliest RD grant at N+`T_WTR`.
  - RD grant at N → earliest WR grant at N+`T_RTW`.
- **Throughput:** with all counters at zero, a new grant is possible every cycle. The command bus can carry one command per cycle.
- **Simultaneous events:** a request arriving in the same cycle its counter reaches 0 is eligible in that cycle. The counter check uses the registered value, which is already 0.

## Test plan

- **Reset:** assert `rst` for 3 cycles with all requests high. Required: all grants 0, `cmd_valid_o=0`, `cmd_o=0`; after release, the first grant goes to bank 0 RD.
- **Round-robin:** RD requests held on banks 0–3, `T_CCD=2`. Required: grants to banks 0,1,2,3,0 on cycles 0,2,4,6,8; `cmd_o=2` with the matching `cmd_ba_o` one cycle after each grant.
- **Priority:** same cycle, bank 1 ACT, bank 2 PRE, bank 3 REF, no column requests. Required: ACT to bank 1 is granted first.
  - If a new ACT arrives each time the previous one is granted, PRE is granted within the `T_RRD` gap after the ACT.
  - REF is granted once nothing else is eligible.
- **Turnaround:** WR granted to bank 0 at cycle 0, RD held on bank 1. Required: RD granted at cycle 3 (`T_WTR=3`), not earlier. Symmetric RD→WR case: WR granted at cycle 4.
- **Consume-only-on-grant:** RD request on bank 2 dropped one cycle before its eligibility. Required: no grant; `rr_col` pointer unchanged; `cmd_valid_o` stays 0.
- **Mid-stream reset:** assert `rst` one cycle after a WR grant (`wtr_cnt=2`). Required: after release, an RD is grantable immediately.
